// File: rtl/ex_mdu_if.sv
// EX-stage multiply/divide unit port bundle: pipeline-side controls and operands in,
// HI/LO and pipeline status out.
interface ex_mdu_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        hilo_rd;
   logic        flush;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall_req;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata, hilo_rd, flush,
      input  hi, lo, busy, done, stall_req
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata, hilo_rd, flush,
      output hi, lo, busy, done, stall_req
   );
endinterface

// File: rtl/ex_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: 33 cycles start-to-DONE, stalls the front end.
// MDU_FAST_MULT_EN: multiplies finish after one CALC cycle using a full combinational product.
module ex_mdu (
   input logic   clk,
   input logic   reset,
   ex_mdu_if.slave mdu
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi_q, lo_q;
   logic [63:0] acc;

   logic        sgn_q, is_div, last;
   logic [31:0] b_mag, a_in_mag;
   logic [32:0] mul_sum, div_trial;
   logic [63:0] mul_nxt, div_nxt, acc_nxt, prod_mag;
   logic [31:0] q_mag, r_mag;
   logic [31:0] res_hi, res_lo;

   assign sgn_q    = ~op_q[0];
   assign is_div   = op_q[1];
   assign b_mag    = (sgn_q && b_q[31]) ? -b_q : b_q;
   assign a_in_mag = (!mdu.op[0] && mdu.a[31]) ? -mdu.a : mdu.a;

   // acc = {partial product | remainder, multiplier | quotient}; low half seeded with |a|
   assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, b_mag};
   assign mul_nxt   = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
   assign div_trial = acc[63:31] - {1'b0, b_mag};
   assign div_nxt   = div_trial[32] ? {acc[62:0], 1'b0}
                                    : {div_trial[31:0], acc[30:0], 1'b1};
   assign acc_nxt   = is_div ? div_nxt : mul_nxt;

`ifdef MDU_FAST_MULT_EN
   assign last     = (cnt == 5'd31) || !is_div;
   assign prod_mag = {32'b0, acc[31:0]} * {32'b0, b_mag};
`else
   assign last     = (cnt == 5'd31);
   assign prod_mag = acc_nxt;
`endif

   assign q_mag = acc_nxt[31:0];
   assign r_mag = acc_nxt[63:32];

   always_comb begin
      logic [63:0] prod;
      prod   = (sgn_q && (a_q[31] ^ b_q[31])) ? -prod_mag : prod_mag;
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      if (is_div) begin
         if (b_q == 32'd0) begin
            res_hi = a_q;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_lo = (sgn_q && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
            res_hi = (sgn_q && a_q[31]) ? -r_mag : r_mag;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mdu.start && !mdu.flush) state_nxt = CALC;
         CALC:    if (mdu.flush)               state_nxt = IDLE;
                  else if (last)               state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mdu.busy      = (state != IDLE);
      mdu.done      = (state == DONE);
      mdu.stall_req = (state == CALC) ||
                      (mdu.hilo_rd && state != IDLE) ||
                      (mdu.start && state != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= 5'd0;
         op_q <= 2'd0;
         a_q  <= 32'd0;
         b_q  <= 32'd0;
         acc  <= 64'd0;
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (mdu.hi_we) hi_q <= mdu.wdata;
               if (mdu.lo_we) lo_q <= mdu.wdata;
               if (mdu.start && !mdu.flush) begin
                  op_q <= mdu.op;
                  a_q  <= mdu.a;
                  b_q  <= mdu.b;
                  cnt  <= 5'd0;
                  acc  <= {32'd0, a_in_mag};
               end
            end
            CALC: begin
               if (!mdu.flush) begin
                  cnt <= cnt + 5'd1;
                  acc <= acc_nxt;
                  if (last) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mdu.hi = hi_q;
   assign mdu.lo = lo_q;
endmodule
